// File: rtl/fwd_unit_pkg.sv
// Shared types and constants for operand forwarding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fwd_unit_pkg;

  localparam int XLEN_DEF = 64;
  localparam int REG_W    = 5;

  // One forwarding stage at the default data width.
  typedef struct packed {
    logic             rd_en;
    logic [REG_W-1:0] rd;
    logic [XLEN_DEF-1:0] data;
    logic             ok;
  } fwd_stage_t;

endpackage

// File: rtl/fwd_select.sv
// Single-source operand resolution: youngest-hit priority search plus hold register.
// Latency: combinational operand/valid; hold register captures at rising edge.
// Backpressure: holds a ready operand while exe stalls; cleared on exe_ready or exe_flush.
module fwd_select
  import fwd_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_FWD = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            exe_valid,
  input  logic                            exe_ready,
  input  logic                            exe_flush,
  input  logic                            rs_en,
  input  logic [REG_W-1:0]                rs_idx,
  input  logic [XLEN-1:0]                 rs_rf,
  input  logic [NUM_FWD-1:0]              fwd_rd_en,
  input  logic [NUM_FWD-1:0][REG_W-1:0]   fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]    fwd_data,
  input  logic [NUM_FWD-1:0]              fwd_ok,
  output logic [XLEN-1:0]                 opnd,
  output logic                            opnd_valid
);

  logic [XLEN-1:0] live_dat;
  logic            live_ok;
  logic            held;
  logic [XLEN-1:0] held_dat;

  // Search oldest to youngest so the youngest hit overwrites; a pending
  // youngest hit blocks older stages and the register file.
  always_comb begin
    live_dat = rs_rf;
    live_ok  = 1'b1;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (rs_en && fwd_rd_en[j] && (fwd_rd[j] == rs_idx) && (rs_idx != '0)) begin
        live_dat = fwd_data[j];
        live_ok  = fwd_ok[j];
      end
    end
  end

  // Capture a ready operand once while exe stalls; release wins over capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held     <= 1'b0;
      held_dat <= '0;
    end else if (exe_ready || exe_flush) begin
      held     <= 1'b0;
      held_dat <= '0;
    end else if (exe_valid && !held && rs_en && live_ok) begin
      held     <= 1'b1;
      held_dat <= live_dat;
    end
  end

  assign opnd       = held ? held_dat : live_dat;
  assign opnd_valid = held | live_ok | ~rs_en;

endmodule

// File: rtl/fwd_unit.sv
// Operand forwarding unit: per-source resolution plus operand-stall cycle counter.
// Latency: zero-cycle combinational resolution; stall counter updates at rising edge.
// Backpressure: operands held across exe stalls; stall_cnt saturates at all-ones.
module fwd_unit
  import fwd_unit_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            exe_valid,
  input  logic                            exe_ready,
  input  logic                            exe_flush,
  input  logic [NUM_SRC-1:0]              rs_en,
  input  logic [NUM_SRC-1:0][REG_W-1:0]   rs_idx,
  input  logic [NUM_SRC-1:0][XLEN-1:0]    rs_rf,
  input  logic [NUM_FWD-1:0]              fwd_rd_en,
  input  logic [NUM_FWD-1:0][REG_W-1:0]   fwd_rd,
  input  logic [NUM_FWD-1:0][XLEN-1:0]    fwd_data,
  input  logic [NUM_FWD-1:0]              fwd_ok,
  output logic [NUM_SRC-1:0][XLEN-1:0]    opnd,
  output logic [NUM_SRC-1:0]              opnd_valid,
  output logic                            all_valid,
  output logic [CNT_W-1:0]                stall_cnt
);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .XLEN    (XLEN),
      .NUM_FWD (NUM_FWD)
    ) u_sel (
      .clk        (clk),
      .rst        (rst),
      .exe_valid  (exe_valid),
      .exe_ready  (exe_ready),
      .exe_flush  (exe_flush),
      .rs_en      (rs_en[i]),
      .rs_idx     (rs_idx[i]),
      .rs_rf      (rs_rf[i]),
      .fwd_rd_en  (fwd_rd_en),
      .fwd_rd     (fwd_rd),
      .fwd_data   (fwd_data),
      .fwd_ok     (fwd_ok),
      .opnd       (opnd[i]),
      .opnd_valid (opnd_valid[i])
    );
  end

  assign all_valid = &opnd_valid;

  // Count cycles a live, unflushed instruction waits on operands; stick at max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (exe_valid && !exe_flush && !all_valid && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_unit.sv
// Directed self-checking bench for fwd_unit (stall counter narrowed to 4 bits).
// Latency: combinational checks 1 ns after input changes; state checks after edges.
// Backpressure: exercised via exe_ready/exe_flush sequences.
module tb_fwd_unit;
  import fwd_unit_pkg::*;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        exe_valid, exe_ready, exe_flush;
  logic [1:0]                  rs_en;
  logic [1:0][REG_W-1:0]       rs_idx;
  logic [1:0][XLEN-1:0]        rs_rf;
  logic [1:0]                  fwd_rd_en;
  logic [1:0][REG_W-1:0]       fwd_rd;
  logic [1:0][XLEN-1:0]        fwd_data;
  logic [1:0]                  fwd_ok;
  logic [1:0][XLEN-1:0]        opnd;
  logic [1:0]                  opnd_valid;
  logic                        all_valid;
  logic [CNT_W-1:0]            stall_cnt;

  int checks   = 0;
  int failures = 0;

  fwd_unit #(.XLEN(XLEN), .NUM_SRC(2), .NUM_FWD(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .exe_valid  (exe_valid),
    .exe_ready  (exe_ready),
    .exe_flush  (exe_flush),
    .rs_en      (rs_en),
    .rs_idx     (rs_idx),
    .rs_rf      (rs_rf),
    .fwd_rd_en  (fwd_rd_en),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .fwd_ok     (fwd_ok),
    .opnd       (opnd),
    .opnd_valid (opnd_valid),
    .all_valid  (all_valid),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       en;
    logic [4:0]       idx0, idx1;
    logic [63:0]      rf0, rf1;
    fwd_stage_t       st0, st1;
    logic [63:0]      e0, e1;
    logic [1:0]       ev;
    logic             ea;
  } vec_t;

  vec_t tbl [7];

  function automatic fwd_stage_t st(input logic en, input logic [4:0] rd,
                                    input logic [63:0] d, input logic ok);
    fwd_stage_t s;
    s.rd_en = en;
    s.rd    = rd;
    s.data  = d;
    s.ok    = ok;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_stage(input int j, input fwd_stage_t s);
    fwd_rd_en[j] = s.rd_en;
    fwd_rd[j]    = s.rd;
    fwd_data[j]  = s.data;
    fwd_ok[j]    = s.ok;
  endtask

  task automatic apply(input vec_t v);
    rs_en     = v.en;
    rs_idx[0] = v.idx0;
    rs_idx[1] = v.idx1;
    rs_rf[0]  = v.rf0;
    rs_rf[1]  = v.rf1;
    set_stage(0, v.st0);
    set_stage(1, v.st1);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; exe_valid = 0; exe_ready = 0; exe_flush = 0;
    rs_en = '0; rs_idx = '0; rs_rf = '0;
    fwd_rd_en = '0; fwd_rd = '0; fwd_data = '0; fwd_ok = '0;

    tbl[0] = '{2'b01, 5'd5, 5'd3, 64'h1000, 64'h33,
               st(1, 5, 64'hAA, 1), st(1, 5, 64'hBB, 1), 64'hAA, 64'h33, 2'b11, 1'b1};
    tbl[1] = '{2'b10, 5'd0, 5'd7, 64'h1, 64'h2000,
               st(1, 7, 64'h70, 0), st(1, 7, 64'h71, 1), 64'h1, 64'h70, 2'b01, 1'b0};
    tbl[2] = '{2'b11, 5'd0, 5'd4, 64'h99, 64'h44,
               st(1, 0, 64'h55, 1), st(1, 8, 64'h77, 1), 64'h99, 64'h44, 2'b11, 1'b1};
    tbl[3] = '{2'b11, 5'd9, 5'd3, 64'h90, 64'h30,
               st(1, 3, 64'hD3, 1), st(1, 9, 64'hC9, 1), 64'hC9, 64'hD3, 2'b11, 1'b1};
    tbl[4] = '{2'b11, 5'd9, 5'd9, 64'h90, 64'h91,
               st(0, 9, 64'hE0, 0), st(0, 9, 64'hE1, 0), 64'h90, 64'h91, 2'b11, 1'b1};
    tbl[5] = '{2'b01, 5'd12, 5'd12, 64'h120, 64'h121,
               st(1, 1, 64'hF0, 1), st(1, 12, 64'hF1, 0), 64'hF1, 64'h121, 2'b10, 1'b0};
    tbl[6] = '{2'b11, 5'd31, 5'd31, 64'h0, 64'h0,
               st(1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1), st(1, 31, 64'h0, 0),
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b1};

    // Reset state: asynchronous clear, live path only.
    #2;
    chk("rst_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_valid", 64'(opnd_valid), 64'b11);
    do_reset();

    // Combinational resolution table (exe idle, no captures).
    for (int k = 0; k < 7; k++) begin
      apply(tbl[k]);
      #1;
      chk($sformatf("v%0d_opnd0", k), opnd[0], tbl[k].e0);
      chk($sformatf("v%0d_opnd1", k), opnd[1], tbl[k].e1);
      chk($sformatf("v%0d_valid", k), 64'(opnd_valid), 64'(tbl[k].ev));
      chk($sformatf("v%0d_all", k), 64'(all_valid), 64'(tbl[k].ea));
      tick();
    end
    chk("idle_cnt", 64'(stall_cnt), 64'd0);

    // Stall counting on a pending youngest stage, flush pause, saturation.
    do_reset();
    apply(tbl[1]);
    exe_valid = 1;
    #1;
    chk("stall_start", 64'(stall_cnt), 64'd0);
    repeat (3) tick();
    chk("stall_3", 64'(stall_cnt), 64'd3);
    exe_flush = 1;
    tick();
    chk("stall_flush", 64'(stall_cnt), 64'd3);
    exe_flush = 0;
    repeat (14) tick();
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    exe_valid = 0;

    // Staggered capture across a two-cycle exe stall, then release.
    do_reset();
    exe_valid = 1; exe_ready = 0;
    rs_en = 2'b11; rs_idx[0] = 5; rs_idx[1] = 6; rs_rf[0] = 64'h500; rs_rf[1] = 64'h600;
    set_stage(0, st(1, 5, 64'h11, 1));
    set_stage(1, st(1, 6, 64'h0, 0));
    #1;
    chk("c1_opnd0", opnd[0], 64'h11);
    chk("c1_valid", 64'(opnd_valid), 64'b01);
    chk("c1_all", 64'(all_valid), 64'd0);
    tick();
    set_stage(0, st(1, 5, 64'h22, 1));
    set_stage(1, st(1, 6, 64'h66, 1));
    #1;
    chk("c2_held0", opnd[0], 64'h11);
    chk("c2_opnd1", opnd[1], 64'h66);
    chk("c2_all", 64'(all_valid), 64'd1);
    chk("c2_cnt", 64'(stall_cnt), 64'd1);
    tick();
    exe_ready = 1;
    set_stage(1, st(1, 6, 64'h67, 1));
    #1;
    chk("c3_held0", opnd[0], 64'h11);
    chk("c3_held1", opnd[1], 64'h66);
    tick();
    exe_ready = 0; exe_valid = 0;
    #1;
    chk("c4_live0", opnd[0], 64'h22);
    chk("c4_live1", opnd[1], 64'h67);
    chk("c4_cnt", 64'(stall_cnt), 64'd1);

    // Capture coincident with flush must not hold.
    exe_valid = 1; exe_flush = 1;
    rs_en = 2'b01;
    set_stage(0, st(1, 5, 64'h11, 1));
    set_stage(1, st(0, 0, 64'h0, 0));
    tick();
    exe_flush = 0; exe_valid = 0;
    set_stage(0, st(1, 5, 64'h22, 1));
    #1;
    chk("flush_nohold", opnd[0], 64'h22);

    // Asynchronous reset mid-hold discards the captured operand.
    exe_valid = 1;
    rs_en = 2'b11;
    set_stage(0, st(1, 5, 64'h33, 1));
    set_stage(1, st(1, 6, 64'h0, 0));
    tick();
    exe_valid = 0;
    set_stage(0, st(1, 5, 64'h44, 1));
    #1;
    chk("hold_pre_rst", opnd[0], 64'h33);
    chk("cnt_pre_rst", 64'(stall_cnt), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_live0", opnd[0], 64'h44);
    chk("rst_cnt_clr", 64'(stall_cnt), 64'd0);
    chk("rst_valid_live", 64'(opnd_valid), 64'b01);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_live0", opnd[0], 64'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_unit.md
FWD_UNIT -- requirements
Module: fwd_unit

Interface
REQ-001 Parameter XLEN, default 64: operand/result data width.
REQ-002 Parameter NUM_SRC, default 2: number of source operands resolved per instruction.
REQ-003 Parameter NUM_FWD, default 2: number of forwarding stages; index 0 is youngest (mem), NUM_FWD-1 oldest (wb).
REQ-004 Parameter CNT_W, default 32: stall-counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 exe_valid  in  1  exe stage holds a live instruction.
REQ-008 exe_ready  in  1  exe stage completes this cycle; operands consumed.
REQ-009 exe_flush  in  1  exe instruction killed.
REQ-010 rs_en  in  NUM_SRC  source i is read.
REQ-011 rs_idx  in  NUM_SRC x 5  source register index.
REQ-012 rs_rf  in  NUM_SRC x XLEN  register-file value of source i.
REQ-013 fwd_rd_en  in  NUM_FWD  stage j writes a register.
REQ-014 fwd_rd  in  NUM_FWD x 5  stage j destination index.
REQ-015 fwd_data  in  NUM_FWD x XLEN  stage j result.
REQ-016 fwd_ok  in  NUM_FWD  stage j result is final (0 = load/multicycle still pending).
REQ-017 opnd  out  NUM_SRC x XLEN  resolved operand values.
REQ-018 opnd_valid  out  NUM_SRC  per-source operand usable.
REQ-019 all_valid  out  1  AND of opnd_valid.
REQ-020 stall_cnt  out  CNT_W  saturating count of operand-stall cycles.

Function
REQ-021 Hit(i,j) = rs_en[i] & fwd_rd_en[j] & fwd_rd[j]==rs_idx[i] & rs_idx[i]!=0; x0 is never forwarded.
REQ-022 Selected stage for source i is the lowest j with Hit(i,j); older stages are ignored even if ready.
REQ-023 Live value: selected stage's fwd_data, else rs_rf[i]; live_ok = fwd_ok of selected stage, else 1.
REQ-024 Selected stage with fwd_ok=0 yields live_ok=0; no fall-through to an older stage or rs_rf.
REQ-025 Per-source hold register: held[i] set and data captured at posedge when exe_valid & !exe_ready & !exe_flush & !held[i] & rs_en[i] & live_ok[i].
REQ-026 Capture is independent per source; a ready source is held while another still waits.
REQ-027 held[i] and its data are cleared at posedge when exe_ready | exe_flush; clear beats capture in the same cycle.
REQ-028 opnd[i] = held[i] ? held data : live value; held data is never overwritten while held[i]=1.
REQ-029 opnd_valid[i] = held[i] | live_ok[i] | !rs_en[i]; resolution is combinational, zero-cycle latency.
REQ-030 stall_cnt increments by 1 each cycle exe_valid & !exe_flush & !all_valid; saturates at all-ones.
REQ-031 NUM_SRC>=1, NUM_FWD>=1; any combination elaborates without width truncation.

Reset
REQ-032 rst asserted immediately clears all held flags, held data to 0 and stall_cnt to 0, regardless of clk.
REQ-033 During and after reset opnd/opnd_valid reflect the live path only; reset mid-stall discards captured operands.

Structure
REQ-034 Shared package holds XLEN default, register-index width (5) and a packed fwd_stage_t struct {rd_en, rd, data, ok}.
REQ-035 One sub-module fwd_select (single-source priority search plus hold register), instantiated NUM_SRC times by generate; stall counter stays in the top.

Verification
REQ-036 rs_idx[0]=5, stage0 rd=5 data=0xAA ok=1, stage1 rd=5 data=0xBB -> opnd[0]=0xAA, valid=1.
REQ-037 rs_idx[1]=7, stage0 rd=7 ok=0, stage1 rd=7 ok=1 -> opnd_valid[1]=0, all_valid=0, stall_cnt +1 per cycle.
REQ-038 rs_idx[0]=0, stage0 rd=0 data=0x55 -> opnd[0]=rs_rf[0], no forward.
REQ-039 exe_ready=0 two cycles, src0 ready 0x11 cycle1 then stage changes to 0x22, src1 ready cycle2 -> opnd[0]=0x11 held, all_valid in cycle2, held cleared after exe_ready.
REQ-040 Capture and exe_flush same cycle -> held stays 0; rst asserted mid-hold -> held cleared asynchronously, stall_cnt=0.
